// File: rtl/pem_fifo_element_pkg.sv
// Shared definitions for the PE-memory elastic FIFO element.
// Stage-type codes select the register behaviour of each pipeline stage.
package pem_fifo_element_pkg;

    localparam int FE_TYPE_PIPE      = 1;
    localparam int FE_TYPE_RDY_BREAK = 2;
    localparam int FE_TYPE_SKID      = 3;

endpackage

// File: rtl/pem_fifo_element_stage.sv
// One valid/ready stage: plain pipe register, ready-breaking register or skid buffer.
// The output payload always comes straight from a register.
module pem_fifo_stage
    import pem_fifo_element_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter int               TYPE           = FE_TYPE_SKID,
    parameter bit               DO_RESET_DATA  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_DATA_VAL = '0
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i
);

    if (TYPE == FE_TYPE_PIPE || TYPE == FE_TYPE_RDY_BREAK) begin : g_single
        logic             vld_q, vld_d;
        logic [WIDTH-1:0] data_q, data_d;
        logic             load;

        // Pipe type lets a drain free the slot in the same cycle; ready-break does not.
        if (TYPE == FE_TYPE_PIPE) begin : g_pipe_rdy
            assign in_rdy_o = ~vld_q | out_rdy_i;
        end else begin : g_break_rdy
            assign in_rdy_o = ~vld_q;
        end

        always_comb begin
            load   = in_vld_i & in_rdy_o;
            vld_d  = vld_q;
            data_d = data_q;
            if (load) begin
                vld_d  = 1'b1;
                data_d = in_data_i;
            end else if (out_rdy_i) begin
                vld_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (!s_rst_n) begin
                vld_q <= 1'b0;
            end else begin
                vld_q <= vld_d;
            end
        end

        always_ff @(posedge clk) begin
            if (!s_rst_n) begin
                if (DO_RESET_DATA) begin
                    data_q <= RESET_DATA_VAL;
                end
            end else begin
                data_q <= data_d;
            end
        end

        assign out_data_o = data_q;
        assign out_vld_o  = vld_q;
    end else if (TYPE == FE_TYPE_SKID) begin : g_skid
        logic             main_vld_q, main_vld_d;
        logic             skid_vld_q, skid_vld_d;
        logic [WIDTH-1:0] main_data_q, main_data_d;
        logic [WIDTH-1:0] skid_data_q, skid_data_d;
        logic             accept;
        logic             drain;

        // The skid entry absorbs the one word that may arrive after out_rdy drops.
        always_comb begin
            accept      = in_vld_i & ~skid_vld_q;
            drain       = main_vld_q & out_rdy_i;
            main_vld_d  = main_vld_q;
            skid_vld_d  = skid_vld_q;
            main_data_d = main_data_q;
            skid_data_d = skid_data_q;
            if (skid_vld_q) begin
                if (drain) begin
                    main_data_d = skid_data_q;
                    skid_vld_d  = 1'b0;
                end
            end else if (accept) begin
                if (!main_vld_q || drain) begin
                    main_data_d = in_data_i;
                    main_vld_d  = 1'b1;
                end else begin
                    skid_data_d = in_data_i;
                    skid_vld_d  = 1'b1;
                end
            end else if (drain) begin
                main_vld_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (!s_rst_n) begin
                main_vld_q <= 1'b0;
                skid_vld_q <= 1'b0;
            end else begin
                main_vld_q <= main_vld_d;
                skid_vld_q <= skid_vld_d;
            end
        end

        always_ff @(posedge clk) begin
            if (!s_rst_n) begin
                if (DO_RESET_DATA) begin
                    main_data_q <= RESET_DATA_VAL;
                    skid_data_q <= RESET_DATA_VAL;
                end
            end else begin
                main_data_q <= main_data_d;
                skid_data_q <= skid_data_d;
            end
        end

        assign in_rdy_o   = ~skid_vld_q;
        assign out_data_o = main_data_q;
        assign out_vld_o  = main_vld_q;
    end else begin : g_bad_type
        $fatal(1, "pem_fifo_stage: illegal stage type %0d", TYPE);
    end

endmodule

// File: rtl/pem_fifo_element.sv
// Elastic buffer built from a chain of DEPTH valid/ready stages.
// Stage 0 sits on the input side; each stage type is taken from TYPE_ARRAY.
module pem_fifo_element
    import pem_fifo_element_pkg::*;
#(
    parameter int                 WIDTH          = 8,
    parameter int                 DEPTH          = 1,
    parameter logic [4*DEPTH-1:0] TYPE_ARRAY     = 4'h3,
    parameter bit                 DO_RESET_DATA  = 1'b0,
    parameter logic [WIDTH-1:0]   RESET_DATA_VAL = '0
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_vld,
    input  logic             out_rdy
);

    if (DEPTH < 1) begin : g_bad_depth
        $fatal(1, "pem_fifo_element: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stg_data [DEPTH+1];
    logic             stg_vld  [DEPTH+1];
    logic             stg_rdy  [DEPTH+1];

    assign stg_data[0]    = in_data;
    assign stg_vld[0]     = in_vld;
    assign in_rdy         = stg_rdy[0];
    assign out_data       = stg_data[DEPTH];
    assign out_vld        = stg_vld[DEPTH];
    assign stg_rdy[DEPTH] = out_rdy;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pem_fifo_stage #(
            .WIDTH         (WIDTH),
            .TYPE          (int'(TYPE_ARRAY[4*i +: 4])),
            .DO_RESET_DATA (DO_RESET_DATA),
            .RESET_DATA_VAL(RESET_DATA_VAL)
        ) u_stage (
            .clk       (clk),
            .s_rst_n   (s_rst_n),
            .in_data_i (stg_data[i]),
            .in_vld_i  (stg_vld[i]),
            .in_rdy_o  (stg_rdy[i]),
            .out_data_o(stg_data[i+1]),
            .out_vld_o (stg_vld[i+1]),
            .out_rdy_i (stg_rdy[i+1])
        );
    end

endmodule

// File: tb/tb_pem_fifo_element.sv
// Directed bench for pem_fifo_element: skid, ready-break and mixed 3-stage chains,
// including data reset values and reset while entries are held.
module tb_pem_fifo_element;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic s_rst_n;

    logic [7:0]  a_in_data, a_out_data;
    logic        a_in_vld, a_in_rdy, a_out_vld, a_out_rdy;
    logic [7:0]  b_in_data, b_out_data;
    logic        b_in_vld, b_in_rdy, b_out_vld, b_out_rdy;
    logic [15:0] c_in_data, c_out_data;
    logic        c_in_vld, c_in_rdy, c_out_vld, c_out_rdy;

    int   checks = 0;
    int   failures = 0;
    int   sent, rcvd;
    logic acc, drn;

    pem_fifo_element #(
        .WIDTH(8), .DEPTH(1), .TYPE_ARRAY(4'h3),
        .DO_RESET_DATA(1'b1), .RESET_DATA_VAL(8'h5C)
    ) u_dut_a (
        .clk(clk), .s_rst_n(s_rst_n),
        .in_data(a_in_data), .in_vld(a_in_vld), .in_rdy(a_in_rdy),
        .out_data(a_out_data), .out_vld(a_out_vld), .out_rdy(a_out_rdy)
    );

    pem_fifo_element #(
        .WIDTH(8), .DEPTH(1), .TYPE_ARRAY(4'h2)
    ) u_dut_b (
        .clk(clk), .s_rst_n(s_rst_n),
        .in_data(b_in_data), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
        .out_data(b_out_data), .out_vld(b_out_vld), .out_rdy(b_out_rdy)
    );

    pem_fifo_element #(
        .WIDTH(16), .DEPTH(3), .TYPE_ARRAY(12'h312)
    ) u_dut_c (
        .clk(clk), .s_rst_n(s_rst_n),
        .in_data(c_in_data), .in_vld(c_in_vld), .in_rdy(c_in_rdy),
        .out_data(c_out_data), .out_vld(c_out_vld), .out_rdy(c_out_rdy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_rst_n   = 1'b0;
        a_in_data = '0; a_in_vld = 1'b0; a_out_rdy = 1'b0;
        b_in_data = '0; b_in_vld = 1'b0; b_out_rdy = 1'b0;
        c_in_data = '0; c_in_vld = 1'b0; c_out_rdy = 1'b0;
        tick();
        tick();
        s_rst_n = 1'b1;

        // Reset state
        check("rst_a_out_vld", a_out_vld, 0);
        check("rst_a_in_rdy", a_in_rdy, 1);
        check("rst_a_out_data", a_out_data, 8'h5C);
        check("rst_b_out_vld", b_out_vld, 0);
        check("rst_b_in_rdy", b_in_rdy, 1);
        check("rst_c_out_vld", c_out_vld, 0);
        check("rst_c_in_rdy", c_in_rdy, 1);

        // Single push through the skid stage, one cycle latency
        a_in_data = 8'hA5; a_in_vld = 1'b1; a_out_rdy = 1'b1;
        #1;
        check("t1_in_rdy_pre", a_in_rdy, 1);
        tick();
        a_in_vld = 1'b0;
        check("t1_out_vld", a_out_vld, 1);
        check("t1_out_data", a_out_data, 8'hA5);
        check("t1_in_rdy_post", a_in_rdy, 1);
        tick();
        check("t1_drained", a_out_vld, 0);

        // Fill main and skid with out_rdy low, then drain in order
        a_out_rdy = 1'b0;
        a_in_data = 8'h01; a_in_vld = 1'b1;
        tick();
        a_in_data = 8'h02;
        #1;
        check("t2_in_rdy_one_held", a_in_rdy, 1);
        tick();
        a_in_vld = 1'b0;
        check("t2_full_in_rdy", a_in_rdy, 0);
        check("t2_full_out_vld", a_out_vld, 1);
        check("t2_full_out_data", a_out_data, 8'h01);
        tick();
        check("t2_hold_in_rdy", a_in_rdy, 0);
        check("t2_hold_out_data", a_out_data, 8'h01);
        a_out_rdy = 1'b1;
        tick();
        check("t2_second_vld", a_out_vld, 1);
        check("t2_second_data", a_out_data, 8'h02);
        check("t2_rdy_back", a_in_rdy, 1);
        tick();
        check("t2_empty", a_out_vld, 0);

        // Continuous stream at full throughput
        for (int i = 0; i < 100; i++) begin
            a_in_data = 8'(i); a_in_vld = 1'b1;
            #1;
            check("t3_stream_in_rdy", a_in_rdy, 1);
            tick();
            check("t3_stream_vld", a_out_vld, 1);
            check("t3_stream_data", a_out_data, i);
        end
        a_in_vld = 1'b0;
        tick();
        check("t3_stream_empty", a_out_vld, 0);

        // Stream with random backpressure, ordered and lossless
        sent = 0; rcvd = 0;
        for (int cyc = 0; cyc < 2000 && rcvd < 100; cyc++) begin
            a_in_vld  = (sent < 100);
            a_in_data = 8'(sent);
            a_out_rdy = 1'($urandom_range(0, 1));
            #1;
            acc = a_in_vld & a_in_rdy;
            drn = a_out_vld & a_out_rdy;
            if (drn) begin
                check("t3_rand_order", a_out_data, rcvd);
                rcvd++;
            end
            if (acc) sent++;
            tick();
        end
        check("t3_rand_count", rcvd, 100);
        a_in_vld = 1'b0; a_out_rdy = 1'b1;
        tick();
        check("t3_rand_empty", a_out_vld, 0);

        // Ready-break stage: one transfer every two cycles
        b_out_rdy = 1'b1; b_in_vld = 1'b1;
        sent = 0;
        for (int k = 0; k < 8; k++) begin
            b_in_data = 8'(sent + 8'h40);
            #1;
            check("t4_in_rdy", b_in_rdy, (k % 2 == 0) ? 1 : 0);
            check("t4_out_vld", b_out_vld, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 1) check("t4_out_data", b_out_data, sent - 1 + 8'h40);
            if (b_in_vld && b_in_rdy) sent++;
            tick();
        end
        b_in_vld = 1'b0;
        tick();
        check("t4_accepted", sent, 4);

        // Three-stage chain idle latency
        c_out_rdy = 1'b1;
        c_in_data = 16'h0BEE; c_in_vld = 1'b1;
        #1;
        check("t5_in_rdy", c_in_rdy, 1);
        tick();
        c_in_vld = 1'b0;
        check("t5_lat_cyc1", c_out_vld, 0);
        tick();
        check("t5_lat_cyc2", c_out_vld, 0);
        tick();
        check("t5_lat_cyc3_vld", c_out_vld, 1);
        check("t5_lat_cyc3_data", c_out_data, 16'h0BEE);
        tick();
        check("t5_lat_empty", c_out_vld, 0);

        // Three-stage chain, random valid and ready, 1000 items
        sent = 0; rcvd = 0;
        for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
            if (!c_in_vld) c_in_vld = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            c_in_data = 16'(sent);
            c_out_rdy = 1'($urandom_range(0, 1));
            #1;
            acc = c_in_vld & c_in_rdy;
            drn = c_out_vld & c_out_rdy;
            if (drn) begin
                check("t5_rand_order", c_out_data, rcvd);
                rcvd++;
            end
            if (acc) sent++;
            tick();
            if (acc) c_in_vld = 1'b0;
        end
        check("t5_rand_count", rcvd, 1000);
        c_in_vld = 1'b0;

        // Reset while two entries are held discards them
        a_out_rdy = 1'b0;
        a_in_data = 8'h11; a_in_vld = 1'b1;
        tick();
        a_in_data = 8'h22;
        tick();
        check("t6_full_before_rst", a_in_rdy, 0);
        a_in_data = 8'h33;
        s_rst_n = 1'b0;
        tick();
        check("t6_rst_out_vld", a_out_vld, 0);
        check("t6_rst_in_rdy", a_in_rdy, 1);
        check("t6_rst_out_data", a_out_data, 8'h5C);
        s_rst_n = 1'b1; a_in_vld = 1'b0; a_out_rdy = 1'b1;
        tick();
        check("t6_no_stale", a_out_vld, 0);
        check("t6_data_reset_kept", a_out_data, 8'h5C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pem_fifo_element.md
Name: pem_fifo_element

Overview:
- Parameterisable chain of valid/ready pipeline stages.
- Used as the elastic input buffer in front of the PE-memory load and store command paths: one load command instance and one store command instance, each WIDTH=PEM_CMD_W, DEPTH=1, TYPE_ARRAY=4'h3.
- Each stage is selectable between a plain pipe register, a ready-breaking register, or a full-throughput skid buffer.
- Data order is preserved; no data is lost or duplicated.

Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 1: number of stages (>=1).
- TYPE_ARRAY, 4'h3: 4 bits per stage; stage i type = TYPE_ARRAY[4*i+:4]; stage 0 is the input side. Legal values 1, 2, 3; any other value is a fatal elaboration error.
- DO_RESET_DATA, 1'b0: 1 = data registers are reset to RESET_DATA_VAL; 0 = data registers are not reset.
- RESET_DATA_VAL, 0: data reset value, WIDTH bits.

Ports:
- clk  in  1  clock
- s_rst_n  in  1  synchronous reset, active-low
- in_data  in  WIDTH  input payload
- in_vld  in  1  input valid
- in_rdy  out  1  input ready
- out_data  out  WIDTH  output payload
- out_vld  out  1  output valid
- out_rdy  in  1  output ready

Behaviour:
- Transfer occurs on the rising clk edge where vld & rdy. The source must hold vld/data stable until accepted.
- Stages are chained: out of stage i feeds in of stage i+1.
- Type 1, pipe register:
  - 1 entry; in_rdy = ~vld_q | out_rdy (combinational ready path).
  - Full throughput.
- Type 2, ready-breaking register:
  - 1 entry; in_rdy = ~vld_q.
  - No combinational path; one transfer every 2 cycles at best.
- Type 3, skid buffer:
  - 2 entries: main register (drives out) and skid register.
  - in_rdy = ~skid_vld, registered; no combinational path in or out.
  - Accept while main empty, or main is draining this cycle: write main.
  - Accept while main full and not draining: write skid.
  - Main drains while skid full: main <= skid; skid clears.
  - Full throughput with out_rdy constantly 1.
- Latency: accept at cycle N -> out_vld=1 at cycle N+1 per stage, for all types.
- out_data is taken directly from a register; no combinational in->out path.
- Simultaneous accept and drain on a full type-1 stage: the new data replaces the drained data; valid stays 1.
- Reset (s_rst_n=0 at clk edge):
  - All vld/skid_vld flags cleared; out_vld=0; in_rdy=1 after the edge.
  - Data registers = RESET_DATA_VAL if DO_RESET_DATA, else unchanged.
  - in_vld is ignored during reset.
  - Reset mid-operation discards all held entries.
- Capacity: type-1 and type-2 stages hold 1 entry; a type-3 stage holds 2.
- Full condition: in_rdy=0 when the chain is full and out_rdy=0.
- Empty condition: out_vld=0.

Decomposition:
- Shared package: stage-type constants FE_TYPE_PIPE=1, FE_TYPE_RDY_BREAK=2, FE_TYPE_SKID=3.
- One sub-module, pem_fifo_stage (WIDTH, TYPE, reset params), generated DEPTH times in the top.

Test Plan:
- WIDTH=8, DEPTH=1, type 3; push 0xA5 at cycle 0 with out_rdy=1 -> out_vld=1, out_data=0xA5 at cycle 1; in_rdy stays 1.
- Type 3, out_rdy=0; push 0x01 then 0x02 -> in_rdy=0 from cycle 2; raise out_rdy -> outputs 0x01 then 0x02 in order; in_rdy=1 again the cycle after skid empties.
- Type 3, stream 0..99 continuously with out_rdy=1 -> 100 outputs on 100 consecutive cycles, in order; random out_rdy -> same ordered sequence, no loss or duplicate.
- Type 2, stream with out_rdy=1 -> one transfer every 2 cycles; in_rdy toggles 1,0,1,0.
- DEPTH=3, TYPE_ARRAY=12'h312, random vld/rdy for 1000 items -> ordered output; latency 3 cycles when idle.
- DO_RESET_DATA=1, RESET_DATA_VAL=8'h5C -> out_data=0x5C, out_vld=0 after reset; assert reset while 2 entries held -> out_vld=0 and in_rdy=1 next cycle, no stale data emitted.
